// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-port memory bus arbiter:
// FSM state encodings, port identifiers and the default wait limit.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_TIMEOUT = 255;

    function automatic int cnt_width(input int t);
        int w;
        w = $clog2(t + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory command port between an
// instruction-fetch port and a load/store data port, with a wait timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic        oIDone,
    output logic [31:0] oIRData,
    output logic        oIErr,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [3:0]  iDBe,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    output logic        oDDone,
    output logic        oDErr,
    output logic [31:0] oDRData,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [3:0]  oMemBe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic        iMemReady,
    input  logic        iMemValid,
    input  logic [31:0] iMemRData,
    output logic        oBusy
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_gnt;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic w_any;
    logic w_win;
    logic w_tmo;
    logic w_resp;

    assign w_any = iIReq | iDReq;

    // Contention goes to whichever port did not win the previous grant
    always_comb begin
        w_win = PORT_I;
        if (iIReq && iDReq)
            w_win = ~r_last;
        else if (iDReq)
            w_win = PORT_D;
    end

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_last  <= PORT_D;
            r_gnt   <= PORT_I;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                        if (w_win == PORT_D) begin
                            r_we    <= iDWe;
                            r_be    <= iDBe;
                            r_addr  <= iDAddr;
                            r_wdata <= iDWData;
                        end else begin
                            r_we    <= 1'b0;
                            r_be    <= 4'hF;
                            r_addr  <= iIAddr;
                            r_wdata <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (iMemReady) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A completion arriving with the timeout still counts
                    if (iMemValid) begin
                        r_rdata <= r_we ? 32'h0 : iMemRData;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_resp  = (r_state == ST_RESP);
    assign oBusy   = (r_state != ST_IDLE);

    assign oIDone  = w_resp && (r_gnt == PORT_I);
    assign oIRData = oIDone ? r_rdata : 32'h0;
    assign oIErr   = oIDone & r_err;

    assign oDDone  = w_resp && (r_gnt == PORT_D);
    assign oDRData = oDDone ? r_rdata : 32'h0;
    assign oDErr   = oDDone & r_err;

    assign oMemReq   = (r_state == ST_ISSUE);
    assign oMemWe    = oMemReq & r_we;
    assign oMemBe    = oMemReq ? r_be : 4'h0;
    assign oMemAddr  = oMemReq ? r_addr : 32'h0;
    assign oMemWData = oMemReq ? r_wdata : 32'h0;

endmodule
